// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and strobes, counts retired instructions and traps.
module main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             instr_valid,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_ADDR,
        S_EXEC_BR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_MEM,
        S_TRAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state, retirement and trap flag.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_EXEC_ADDR;
                    OP_BEQ:        state_d = S_EXEC_BR;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_EXEC_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_EXEC_BR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_R, S_WB_MEM: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // Moore decode per state; FETCH strobes follow instr_valid; reset forces idle values.
    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = instr_valid;
                pc_write  = instr_valid;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
                alu_op    = 2'b10;
                alu_src_a = 1'b1;
            end
            S_EXEC_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_EXEC_BR: begin
                alu_op        = 2'b01;
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
            end
            S_MEM_RD: mem_read  = 1'b1;
            S_MEM_WR: mem_write = 1'b1;
            S_WB_R:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            alu_op        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
        end
    end

    assign illegal = illegal_q & ~rst;
    assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus pushes per-cycle expected output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_main_control_fsm;

    localparam int CW = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {alu_op, src_a, src_b, pc_write, pc_write_cond, pc_src, ir_write,
    //  mem_read, mem_write, reg_write, mem_to_reg, illegal}
    localparam logic [13:0] E_F0   = 14'b00_0_01_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_F1   = 14'b00_0_01_1_0_0_1_0_0_0_0_0;
    localparam logic [13:0] E_DEC  = 14'b00_0_10_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_XR   = 14'b10_1_00_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_XA   = 14'b00_1_10_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_XB   = 14'b01_1_00_0_1_1_0_0_0_0_0_0;
    localparam logic [13:0] E_MRD  = 14'b00_0_00_0_0_0_0_1_0_0_0_0;
    localparam logic [13:0] E_MWR  = 14'b00_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [13:0] E_WBR  = 14'b00_0_00_0_0_0_0_0_0_1_0_0;
    localparam logic [13:0] E_WBM  = 14'b00_0_00_0_0_0_0_0_0_1_1_0;
    localparam logic [13:0] E_TRAP = 14'b00_0_00_0_0_0_0_0_0_0_0_1;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          instr_valid;
    logic          mem_ready;
    logic [1:0]    alu_op;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          pc_write, pc_write_cond, pc_src, ir_write;
    logic          mem_read, mem_write, reg_write, mem_to_reg, illegal;
    logic [CW-1:0] instret;
    logic [13:0]   got_vec;

    typedef struct {
        logic [13:0]   vec;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_cnt = '0;

    main_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    assign got_vec = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
                      ir_write, mem_read, mem_write, reg_write, mem_to_reg, illegal};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_tests++;
            if (got_vec !== e.vec || instret !== e.cnt) begin
                n_fail++;
                $display("FAIL %s: got outputs=%b instret=%0d, expected outputs=%b instret=%0d",
                         e.name, got_vec, instret, e.vec, e.cnt);
            end
        end
    end

    task automatic cyc(input logic r, input logic [6:0] op, input logic iv,
                       input logic mr, input logic [13:0] ev, input logic [CW-1:0] ec,
                       input string nm);
        exp_t e;
        rst = r; opcode = op; instr_valid = iv; mem_ready = mr;
        e.vec = ev; e.cnt = ec; e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_r(input string nm);
        cyc(0, OP_R, 1, 0, E_F1, exp_cnt, {nm, "_fetch"});
        cyc(0, OP_R, 0, 1, E_DEC, exp_cnt, {nm, "_decode"});
        cyc(0, OP_R, 0, 1, E_XR, exp_cnt, {nm, "_exec"});
        cyc(0, OP_R, 0, 0, E_WBR, exp_cnt, {nm, "_wb"});
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_lw(input int waits);
        cyc(0, OP_LW, 1, 0, E_F1, exp_cnt, "lw_fetch");
        cyc(0, OP_LW, 0, 1, E_DEC, exp_cnt, "lw_decode");
        cyc(0, OP_LW, 0, 1, E_XA, exp_cnt, "lw_addr");
        for (int i = 0; i < waits; i++) cyc(0, OP_LW, 0, 0, E_MRD, exp_cnt, "lw_mem_wait");
        cyc(0, OP_LW, 0, 1, E_MRD, exp_cnt, "lw_mem_done");
        cyc(0, OP_LW, 0, 0, E_WBM, exp_cnt, "lw_wb");
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_sw(input int waits);
        cyc(0, OP_SW, 1, 0, E_F1, exp_cnt, "sw_fetch");
        cyc(0, OP_SW, 0, 0, E_DEC, exp_cnt, "sw_decode");
        cyc(0, OP_SW, 0, 0, E_XA, exp_cnt, "sw_addr");
        for (int i = 0; i < waits; i++) cyc(0, OP_SW, 0, 0, E_MWR, exp_cnt, "sw_mem_wait");
        cyc(0, OP_SW, 0, 1, E_MWR, exp_cnt, "sw_mem_done");
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_beq();
        cyc(0, OP_BEQ, 1, 0, E_F1, exp_cnt, "beq_fetch");
        cyc(0, OP_BEQ, 0, 0, E_DEC, exp_cnt, "beq_decode");
        cyc(0, OP_BEQ, 0, 1, E_XB, exp_cnt, "beq_exec");
        exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; instr_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, OP_R, 1, 1, E_F0, '0, "reset_forced");
        cyc(1, OP_R, 0, 0, E_F0, '0, "reset_hold");

        do_r("r1");
        do_lw(3);
        do_sw(0);
        do_beq();
        for (int i = 0; i < 5; i++) cyc(0, OP_R, 0, 1, E_F0, exp_cnt, "idle_fetch");

        // Reset during a store wait abandons the store without retiring it.
        cyc(0, OP_SW, 1, 0, E_F1, exp_cnt, "swrst_fetch");
        cyc(0, OP_SW, 0, 0, E_DEC, exp_cnt, "swrst_decode");
        cyc(0, OP_SW, 0, 0, E_XA, exp_cnt, "swrst_addr");
        cyc(0, OP_SW, 0, 0, E_MWR, exp_cnt, "swrst_wait1");
        cyc(0, OP_SW, 0, 0, E_MWR, exp_cnt, "swrst_wait2");
        cyc(1, OP_SW, 0, 1, E_F0, '0, "swrst_reset");
        exp_cnt = '0;
        cyc(0, OP_SW, 0, 0, E_F0, exp_cnt, "swrst_after");

        for (int i = 0; i < 16; i++) do_r("wrap");
        cyc(0, OP_R, 0, 0, E_F0, exp_cnt, "wrap_result");

        cyc(0, OP_BAD, 1, 0, E_F1, exp_cnt, "bad_fetch");
        cyc(0, OP_BAD, 0, 0, E_DEC, exp_cnt, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(0, OP_BAD, 1, 1, E_TRAP, exp_cnt, "trap_hold");
        cyc(1, OP_BAD, 1, 1, E_F0, '0, "trap_reset");
        exp_cnt = '0;
        cyc(0, OP_BAD, 0, 0, E_F0, exp_cnt, "trap_cleared");
        do_r("r_after_trap");
        cyc(0, OP_R, 0, 0, E_F0, exp_cnt, "final_fetch");

        @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main control unit for the RISC-V datapath. Steps each instruction through fetch, decode, execute, memory and writeback, with handshakes to instruction and data memory. It is the producer of the `alu_op` code that the ALU control decoder consumes: it drives `alu_op` plus all datapath enables and select lines. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 7: `instr[6:0]` from the instruction register, sampled in DECODE.
- `instr_valid` input 1: instruction memory response valid; the fetch word is present.
- `mem_ready` input 1: data memory completed the current read or write.
- `alu_op` output 2: 00 add, 01 subtract/compare, 10 decode funct3/funct7.
- `alu_src_a` output 1: 0 = PC, 1 = rs1.
- `alu_src_b` output 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `pc_write` output 1: unconditional PC load strobe.
- `pc_write_cond` output 1: PC load when the ALU zero flag is set (BEQ).
- `pc_src` output 1: 0 = ALU result, 1 = ALUOut register.
- `ir_write` output 1: instruction register load strobe.
- `mem_read` output 1: data memory read request, held until `mem_ready`.
- `mem_write` output 1: data memory write request, held until `mem_ready`.
- `reg_write` output 1: register file write strobe.
- `mem_to_reg` output 1: writeback source; 0 = ALUOut, 1 = MDR.
- `illegal` output 1: sticky unsupported-opcode flag.
- `instret` output CNT_W: retired-instruction count.

## Operation
- Supported opcodes:
  - R-type 0110011
  - LW 0000011
  - SW 0100011
  - BEQ 1100011
  - Any other opcode is illegal.
- States and transitions:
  - FETCH → DECODE when `instr_valid`=1; otherwise stays in FETCH.
  - DECODE → EXEC_R (R-type), EXEC_ADDR (LW/SW), EXEC_BR (BEQ), or TRAP (any other opcode).
  - EXEC_R → WB_R.
  - EXEC_ADDR → MEM_RD (LW) or MEM_WR (SW). The opcode is re-read from the held instruction register.
  - MEM_RD → WB_MEM when `mem_ready`=1; otherwise stays.
  - MEM_WR → FETCH when `mem_ready`=1; otherwise stays.
  - EXEC_BR, WB_R and WB_MEM → FETCH.
  - TRAP is terminal; only `rst` exits it.
- Output decode: Moore, from state only, with two Mealy exceptions gated by handshake inputs.
  - FETCH: `alu_op`=00, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=0. `ir_write` = `pc_write` = `instr_valid` (Mealy).
  - DECODE: `alu_op`=00, `alu_src_a`=0, `alu_src_b`=10. This precomputes the branch target into ALUOut.
  - EXEC_R: `alu_op`=10, `alu_src_a`=1, `alu_src_b`=00.
  - EXEC_ADDR: `alu_op`=00, `alu_src_a`=1, `alu_src_b`=10.
  - EXEC_BR: `alu_op`=01, `alu_src_a`=1, `alu_src_b`=00, `pc_write_cond`=1, `pc_src`=1.
  - MEM_RD: `mem_read`=1.
  - MEM_WR: `mem_write`=1.
  - WB_R: `reg_write`=1, `mem_to_reg`=0.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1.
  - TRAP: all strobes 0, `illegal`=1.
  - All outputs not listed for a state are 0.
- `instret` increments by 1 in the cycle leaving WB_R, WB_MEM or EXEC_BR, and on the MEM_WR exit edge. It wraps modulo 2^CNT_W and does not saturate.
- `illegal` is set on the DECODE→TRAP edge and cleared only by `rst`.

## Timing
- Reset: the state register loads FETCH.
- While `rst`=1, outputs are forced as follows:
  - All strobes forced to 0: `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`.
  - `illegal`=0 and `instret`=0.
  - `alu_op`=00, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=0, `mem_to_reg`=0.
- Reset mid-instruction (including during a memory wait): abandon the instruction, return to FETCH, do not count it.
- Latency with zero-wait memory, counted in cycles from the FETCH cycle that sees `instr_valid`:
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
- Each memory wait cycle adds 1 cycle.
- Handshake rules:
  - `mem_read` and `mem_write` stay asserted and stable until the cycle in which `mem_ready`=1.
  - `mem_ready` arriving in any state other than MEM_RD or MEM_WR is ignored.
  - `instr_valid` is sampled only in FETCH.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- Exactly one of `reg_write` or `mem_write` completes per LW/SW.

## Test plan
- **Reset, then R-type (0110011), `instr_valid`=1 immediately:**
  - FETCH shows `ir_write`=`pc_write`=1.
  - EXEC_R shows `alu_op`=10.
  - WB_R shows `reg_write`=1.
  - Back in FETCH at cycle 4; `instret`=1.
- **LW with `mem_ready` low for 3 cycles:**
  - `mem_read` is held for 4 cycles.
  - WB_MEM shows `mem_to_reg`=1.
  - Total 8 cycles; `instret` increments once.
- **SW then BEQ back-to-back:**
  - SW: `mem_write` for 1 cycle, `reg_write` never asserted.
  - BEQ: EXEC_BR shows `alu_op`=01, `pc_write_cond`=1, `pc_src`=1.
  - `instret`=2 after 7 cycles.
- **Opcode 1111111:**
  - DECODE→TRAP; `illegal`=1.
  - No further strobes for 20 cycles despite `instr_valid`=1.
  - `rst` clears `illegal` and returns to FETCH.
- **`rst` asserted during MEM_WR wait:**
  - Next cycle is FETCH, `mem_write`=0, `instret` unchanged from its pre-reset value (then 0 after reset).
- **`CNT_W`=4, 16 R-type instructions:**
  - `instret` wraps 15→0; `instr_valid` held low 5 cycles in FETCH keeps all strobes 0.
